// File: rtl/uart_screen_pkg.sv
// rtl/uart_screen_pkg.sv - shared state encoding and byte constants for the UART screen controller
package uart_screen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_CLEAR  = 2'd2
  } state_e;

  localparam logic [7:0] LF          = 8'h0A;
  localparam logic [7:0] CR          = 8'h0D;
  localparam logic [7:0] BS          = 8'h08;
  localparam logic [7:0] FF          = 8'h0C;
  localparam logic [7:0] SPACE       = 8'h20;
  localparam logic [7:0] CURSOR_CHAR = 8'h5F;

  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_MIN) && (b <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/screen_buf_ram.sv
// rtl/screen_buf_ram.sv - character buffer, one synchronous write port, two combinational read taps
module screen_buf_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [7:0]    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_b
);

  logic [7:0] mem [DEPTH];

  // No reset: the controller sweeps every entry with spaces on reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/uart_screen_ctrl.sv
// rtl/uart_screen_ctrl.sv - UART byte stream to terminal character buffer; optional UART_SCREEN_CURSOR_BLINK_EN
module uart_screen_ctrl
  import uart_screen_pkg::*;
#(
  parameter int COLS         = 16,
  parameter int ROWS         = 4,
  parameter int BLINK_CYCLES = 13500000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_byte,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [$clog2(ROWS*COLS)-1:0]  i_char_addr,
  output logic [7:0]                    o_char,
  output logic [$clog2(ROWS)-1:0]       o_cursor_row,
  output logic [$clog2(COLS)-1:0]       o_cursor_col,
  output logic                          o_busy
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [AW-1:0] K_LAST      = AW'(N - 1);
  localparam logic [AW-1:0] K_SHIFT_END = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] ROW_OFS     = AW'(COLS);
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    char_q;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_data;
  logic [7:0]    rd_data;
  logic [AW-1:0] cursor_addr;
  logic          do_newline;

  assign cursor_addr = {row_q, col_q};

  screen_buf_ram #(.DEPTH(N), .AW(AW)) u_buf (
    .clk     (i_clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (i_char_addr),
    .rdata_a (rd_data),
    .raddr_b (src_addr),
    .rdata_b (src_data)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    row_d      = row_q;
    col_d      = col_q;
    we         = 1'b0;
    waddr      = k_q;
    wdata      = SPACE;
    src_addr   = k_q + ROW_OFS;
    do_newline = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (is_printable(i_byte)) begin
            we    = 1'b1;
            waddr = cursor_addr;
            wdata = i_byte;
            if (col_q == COL_LAST) begin
              col_d      = '0;
              do_newline = 1'b1;
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            case (i_byte)
              LF: begin
                col_d      = '0;
                do_newline = 1'b1;
              end
              CR: col_d = '0;
              BS: begin
                if (col_q != '0) begin
                  col_d = col_q - CW'(1);
                  we    = 1'b1;
                  waddr = {row_q, col_q - CW'(1)};
                  wdata = SPACE;
                end
              end
              FF: begin
                state_d = ST_CLEAR;
                k_d     = '0;
                row_d   = '0;
                col_d   = '0;
              end
              default: ;
            endcase
          end
        end
        // Newline on the last row keeps the cursor row and scrolls instead.
        if (do_newline) begin
          if (row_q == ROW_LAST) begin
            state_d = ST_SCROLL;
            k_d     = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      ST_SCROLL: begin
        we    = 1'b1;
        wdata = (k_q < K_SHIFT_END) ? src_data : SPACE;
        k_d   = k_q + AW'(1);
        if (k_q == K_LAST) begin
          state_d = ST_IDLE;
          k_d     = '0;
        end
      end
      ST_CLEAR: begin
        we    = 1'b1;
        wdata = SPACE;
        k_d   = k_q + AW'(1);
        if (k_q == K_LAST) begin
          state_d = ST_IDLE;
          k_d     = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_CLEAR;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      char_q  <= SPACE;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      col_q   <= col_d;
      char_q  <= rd_data;
    end
  end

  assign o_ready      = (state_q == ST_IDLE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_cursor_row = row_q;
  assign o_cursor_col = col_q;

`ifdef UART_SCREEN_CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [AW-1:0] addr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      addr_q      <= '0;
    end else begin
      addr_q <= i_char_addr;
      if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // addr_q matches the address char_q was fetched from, so the overlay lines up with the data.
  assign o_char = (blink_phase && (state_q == ST_IDLE) && (addr_q == cursor_addr))
                  ? CURSOR_CHAR : char_q;
`else
  assign o_char = char_q;
`endif

endmodule

// File: tb/tb_uart_screen_ctrl.sv
// tb/tb_uart_screen_ctrl.sv - scoreboard bench for uart_screen_ctrl
module tb_uart_screen_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in;
  logic       valid;
  logic       ready;
  logic [5:0] caddr;
  logic [7:0] ch;
  logic [1:0] crow;
  logic [3:0] ccol;
  logic       busy;

  uart_screen_ctrl #(.COLS(16), .ROWS(4), .BLINK_CYCLES(13500000)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_byte       (byte_in),
    .i_valid      (valid),
    .o_ready      (ready),
    .i_char_addr  (caddr),
    .o_char       (ch),
    .o_cursor_row (crow),
    .o_cursor_col (ccol),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mbuf [64];
  int         mrow;
  int         mcol;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mbuf[i] = 8'h20;
    mrow = 0;
    mcol = 0;
  endtask

  task automatic model_newline(output bit scrolled);
    scrolled = 1'b0;
    if (mrow < 3) begin
      mrow++;
    end else begin
      for (int i = 0; i < 48; i++) mbuf[i] = mbuf[i + 16];
      for (int i = 48; i < 64; i++) mbuf[i] = 8'h20;
      scrolled = 1'b1;
    end
  endtask

  task automatic model_apply(input logic [7:0] b, output bit stall);
    stall = 1'b0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      mbuf[mrow * 16 + mcol] = b;
      if (mcol == 15) begin
        mcol = 0;
        model_newline(stall);
      end else begin
        mcol++;
      end
    end else if (b == 8'h0A) begin
      mcol = 0;
      model_newline(stall);
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        mbuf[mrow * 16 + mcol] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      model_clear();
      stall = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag, input int exp_cycles);
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    bit stall;
    int n = 0;
    valid   = 1'b1;
    byte_in = b;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check({tag, "_accept_timeout"}, ready, 1);
    @(posedge clk); #1;
    valid = 1'b0;
    model_apply(b, stall);
    check({tag, "_rdy"}, ready, {31'd0, !stall});
    if (stall) wait_idle({tag, "_stall_len"}, 64);
  endtask

  task automatic read(input int a, input string tag);
    caddr = 6'(a);
    exp_q.push_back(mbuf[a]);
    @(posedge clk); #1;
    check(tag, ch, exp_q.pop_front());
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, crow, mrow);
    check({tag, "_col"}, ccol, mcol);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    valid   = 1'b0;
    byte_in = 8'h00;
    caddr   = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();

    check("rst_char", ch, 8'h20);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 1);
    check_cursor("rst_cursor");
    wait_idle("rst_clear_len", 64);
    check("rst_busy_done", busy, 0);
    read(0, "rst_a0");
    read(17, "rst_a17");
    read(63, "rst_a63");

    send(8'h41, "A");
    send(8'h42, "B");
    read(0, "ab_a0");
    read(1, "ab_a1");
    check_cursor("ab_cursor");

    send(8'h0C, "ff1");
    for (int i = 0; i < 17; i++) send(8'h30, "zero");
    for (int i = 0; i < 17; i++) read(i, "wrap_a");
    check_cursor("wrap_cursor");

    send(8'h0C, "ff2");
    for (int r = 0; r < 4; r++) begin
      send(8'h52, "R");
      send(8'h30 + 8'(r), "digit");
      send(8'h0A, "lf");
    end
    read(0, "scr_a0");
    read(1, "scr_a1");
    read(16, "scr_a16");
    read(17, "scr_a17");
    read(32, "scr_a32");
    for (int i = 48; i < 64; i++) read(i, "scr_blank");
    check_cursor("scr_cursor");

    send(8'h0C, "ff3");
    send(8'h08, "bs0");
    check_cursor("bs0_cursor");
    read(0, "bs0_a0");
    send(8'h58, "X");
    send(8'h08, "bs1");
    read(0, "bs1_a0");
    check_cursor("bs1_cursor");
    send(8'h0D, "cr_prep");
    send(8'h5A, "Z");
    send(8'h0D, "cr");
    check_cursor("cr_cursor");
    send(8'h01, "ctl");
    check_cursor("ctl_cursor");

    send(8'h48, "H");
    send(8'h49, "I");
    send(8'h0A, "lf2");
    send(8'h7E, "tilde");
    send(8'h0C, "ff4");
    for (int i = 0; i < 64; i++) read(i, "clr_all");
    check_cursor("clr_cursor");

    for (int i = 0; i < 3; i++) send(8'h0A, "pre_lf");
    valid   = 1'b1;
    byte_in = 8'h0A;
    @(posedge clk); #1;
    valid = 1'b0;
    check("mid_scroll_busy", busy, 1);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("mid_rst_busy", busy, 1);
    check_cursor("mid_rst_cursor");
    wait_idle("mid_rst_clear_len", 64);
    read(0, "mid_rst_a0");
    read(63, "mid_rst_a63");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
